// File: rtl/udp_tx_pkg.sv
// udp_tx_arb shared types and defaults.
// Two-channel UDP transmit scheduler.
package udp_tx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_REQ   = 5'b00010,
        ST_SEND  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_GAP   = 5'b10000
    } tx_state_e;

    localparam int CH0 = 0;
    localparam int CH1 = 1;

    localparam logic [15:0] MAX_LEN_DEF = 16'd1472;
    localparam int ACK_TIMEOUT_DEF = 1000;
    localparam int IFG_DEF = 12;

    function automatic logic len_ok(
        input logic [15:0] len,
        input logic [15:0] max_len
    );
        return (len != 16'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/udp_tx_rr_sel.sv
// udp_tx_rr_sel: two-input round-robin picker.
// Keeps the last-served pointer; on a tie the other channel wins.
module udp_tx_rr_sel
    import udp_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    // lone requester wins; on a tie the channel not served last wins
    always_comb begin
        gnt = req;
        if (req[CH0] && req[CH1]) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    // remember who was served when the grant is taken
    always_comb begin
        last_d = last_q;
        if (take && (gnt != 2'b00)) begin
            last_d = gnt[CH1];
        end
    end

    // pointer register; reset leaves ch1 as last so ch0 wins a tie
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/udp_tx_arb.sv
// udp_tx_arb: shares the UDP stack transmit port between two FIFOs.
// Grant, request/ack with timeout, byte streaming, then inter-packet gap.
module udp_tx_arb
    import udp_tx_pkg::*;
#(
    parameter logic [15:0] MAX_LEN     = MAX_LEN_DEF,
    parameter int          ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int          IFG         = IFG_DEF
) (
    input  logic        app_tx_clk,
    input  logic        rstn,
    input  logic        ch0_req,
    input  logic        ch1_req,
    input  logic [15:0] ch0_len,
    input  logic [15:0] ch1_len,
    output logic        ch0_gnt,
    output logic        ch1_gnt,
    output logic        ch0_rd,
    output logic        ch1_rd,
    input  logic [7:0]  ch0_data,
    input  logic [7:0]  ch1_data,
    output logic        ch0_done,
    output logic        ch1_done,
    output logic        err,
    output logic        app_tx_data_request,
    output logic [15:0] app_tx_data_length,
    input  logic        app_tx_ack,
    output logic        app_tx_data_valid,
    output logic [7:0]  app_tx_data,
    output logic        busy
);

    localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] IFG_LAST = 16'(IFG - 1);

    tx_state_e   state_q, state_d;
    logic        sel_q, sel_d;
    logic        bad_q, bad_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        rd_q, rd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        vld_q, vld_d;

    logic [1:0]  pick;
    logic [15:0] pick_len;

    udp_tx_rr_sel u_rr (
        .clk  (app_tx_clk),
        .rstn (rstn),
        .req  ({ch1_req, ch0_req}),
        .take (state_q == ST_IDLE),
        .gnt  (pick)
    );

    assign pick_len = pick[CH1] ? ch1_len : ch0_len;

    // next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        bad_d   = bad_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gnt_d   = 2'b00;
        rd_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        req_d   = 1'b0;
        vld_d   = rd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick != 2'b00) begin
                    sel_d   = pick[CH1];
                    len_d   = pick_len;
                    bad_d   = !len_ok(pick_len, MAX_LEN);
                    gnt_d   = pick;
                    req_d   = len_ok(pick_len, MAX_LEN);
                    cnt_d   = 16'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 16'd1;
                if (bad_q) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                end else if (app_tx_ack) begin
                    rd_d    = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_SEND;
                end else if (cnt_q == TO_LAST) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_GAP;
                end else begin
                    req_d = 1'b1;
                end
            end
            ST_SEND: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == len_q - 16'd1) begin
                    done_d  = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_DRAIN;
                end else begin
                    rd_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                cnt_d   = 16'd0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers; reset drops any packet in flight
    always_ff @(posedge app_tx_clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            sel_q   <= 1'b0;
            bad_q   <= 1'b0;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            gnt_q   <= 2'b00;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            bad_q   <= bad_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
        end
    end

    assign ch0_gnt             = gnt_q[CH0];
    assign ch1_gnt             = gnt_q[CH1];
    assign ch0_rd              = rd_q & ~sel_q;
    assign ch1_rd              = rd_q & sel_q;
    assign ch0_done            = done_q & ~sel_q;
    assign ch1_done            = done_q & sel_q;
    assign err                 = err_q;
    assign app_tx_data_request = req_q;
    assign app_tx_data_length  = len_q;
    assign app_tx_data_valid   = vld_q;
    assign app_tx_data         = vld_q ? (sel_q ? ch1_data : ch0_data) : 8'h00;
    assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arb.sv
// tb_udp_tx_arb: randomized bench for udp_tx_arb.
// Packet-level timeline model predicts every output each cycle.
module tb_udp_tx_arb;

    localparam int MAXL = 1472;
    localparam int ATO  = 1000;
    localparam int GAPN = 12;

    typedef struct { int len; int d; } desc_t;
    typedef enum int { K_OK, K_REJ, K_TMO } kind_e;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ch0_req = 1'b0, ch1_req = 1'b0;
    logic [15:0] ch0_len = '0, ch1_len = '0;
    logic [7:0]  ch0_data = '0, ch1_data = '0;
    logic        app_tx_ack = 1'b0;
    logic        ch0_gnt, ch1_gnt, ch0_rd, ch1_rd;
    logic        ch0_done, ch1_done, err;
    logic        app_tx_data_request, app_tx_data_valid, busy;
    logic [15:0] app_tx_data_length;
    logic [7:0]  app_tx_data;

    udp_tx_arb #(
        .MAX_LEN     (16'(MAXL)),
        .ACK_TIMEOUT (ATO),
        .IFG         (GAPN)
    ) dut (
        .app_tx_clk          (clk),
        .rstn                (rstn),
        .ch0_req             (ch0_req),
        .ch1_req             (ch1_req),
        .ch0_len             (ch0_len),
        .ch1_len             (ch1_len),
        .ch0_gnt             (ch0_gnt),
        .ch1_gnt             (ch1_gnt),
        .ch0_rd              (ch0_rd),
        .ch1_rd              (ch1_rd),
        .ch0_data            (ch0_data),
        .ch1_data            (ch1_data),
        .ch0_done            (ch0_done),
        .ch1_done            (ch1_done),
        .err                 (err),
        .app_tx_data_request (app_tx_data_request),
        .app_tx_data_length  (app_tx_data_length),
        .app_tx_ack          (app_tx_ack),
        .app_tx_data_valid   (app_tx_data_valid),
        .app_tx_data         (app_tx_data),
        .busy                (busy)
    );

    always #4 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    desc_t q0[$];
    desc_t q1[$];
    logic [7:0] fifo0 [4096];
    logic [7:0] fifo1 [4096];
    int rp[2];
    int cons[2];

    bit    act = 0;
    int    idle_from = 0;
    int    pg, pd, pl, psel, pbase;
    kind_e pk;
    int    last_ch = 1;
    logic [15:0] len_hold = '0;
    bit    rst_now = 0;
    bit    spur = 0;
    bit    en0 = 1;
    bit    en1 = 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] fbyte(input int c, input int i);
        return (c != 0) ? fifo1[i % 4096] : fifo0[i % 4096];
    endfunction

    task automatic tick();
        logic [1:0] e_gnt, e_rd, e_done, oh;
        logic       e_err, e_req, e_vld;
        logic [7:0] e_data;
        int         a, w, nrd;
        bit         in_win;
        desc_t      ds;
        @(negedge clk);
        cyc++;
        if (act && cyc >= idle_from) act = 0;
        e_gnt = 0; e_rd = 0; e_done = 0; e_err = 0;
        e_req = 0; e_vld = 0; e_data = 0; in_win = 0; a = 0;
        oh = (psel != 0) ? 2'b10 : 2'b01;
        if (act) begin
            a = cyc - pg;
            if (a == 0) e_gnt = oh;
            case (pk)
                K_OK: begin
                    e_req = (a < pd);
                    in_win = e_req;
                    if (a >= pd && a < pd + pl) e_rd = oh;
                    if (a > pd && a <= pd + pl) begin
                        e_vld = 1;
                        e_data = fbyte(psel, pbase + a - pd - 1);
                    end
                    if (a == pd + pl) e_done = oh;
                end
                K_REJ: begin
                    in_win = (a == 0);
                    if (a == 1) begin e_done = oh; e_err = 1; end
                end
                default: begin
                    e_req = (a < ATO);
                    in_win = e_req;
                    if (a == ATO) begin e_done = oh; e_err = 1; end
                end
            endcase
        end
        check("gnt",  32'({ch1_gnt, ch0_gnt}), 32'(e_gnt));
        check("rd",   32'({ch1_rd, ch0_rd}), 32'(e_rd));
        check("done", 32'({ch1_done, ch0_done}), 32'(e_done));
        check("err",  32'(err), 32'(e_err));
        check("req",  32'(app_tx_data_request), 32'(e_req));
        check("vld",  32'(app_tx_data_valid), 32'(e_vld));
        check("data", 32'(app_tx_data), 32'(e_data));
        check("len",  32'(app_tx_data_length), 32'(len_hold));
        check("busy", 32'(busy), 32'(act));
        // FIFOs present the next byte the cycle after a read
        if (ch0_rd) begin ch0_data = fifo0[rp[0] % 4096]; rp[0]++; end
        if (ch1_rd) begin ch1_data = fifo1[rp[1] % 4096]; rp[1]++; end
        // requesters drop req on grant
        if (ch0_gnt && q0.size() > 0) q0.delete(0);
        if (ch1_gnt && q1.size() > 0) q1.delete(0);
        ch0_req = en0 && q0.size() > 0 && !ch0_gnt;
        ch1_req = en1 && q1.size() > 0 && !ch1_gnt;
        ch0_len = (q0.size() > 0) ? 16'(q0[0].len) : 16'($urandom);
        ch1_len = (q1.size() > 0) ? 16'(q1[0].len) : 16'($urandom);
        if (rst_now) begin
            rst_now = 0;
            rstn = 0;
            app_tx_ack = 0;
            if (act && pk == K_OK && a >= pd) begin
                nrd = a - pd + 1;
                cons[psel] = pbase + ((nrd < pl) ? nrd : pl);
            end
            act = 0;
            idle_from = cyc + 1;
            len_hold = '0;
            last_ch = 1;
        end else begin
            rstn = 1;
            if (act && pk == K_OK && a == pd - 1) app_tx_ack = 1;
            else if (spur && !in_win) app_tx_ack = ($urandom_range(0, 7) == 0);
            else app_tx_ack = 0;
        end
        // predict the next grant from the arbitration rule
        if (rstn && !act && cyc >= idle_from && (ch0_req || ch1_req)) begin
            if (ch0_req && ch1_req) w = (last_ch == 1) ? 0 : 1;
            else w = ch1_req ? 1 : 0;
            ds = (w != 0) ? q1[0] : q0[0];
            act = 1;
            pg = cyc + 1;
            psel = w;
            pl = ds.len;
            pd = ds.d;
            pbase = cons[w];
            last_ch = w;
            len_hold = 16'(pl);
            if (pl == 0 || pl > MAXL) begin
                pk = K_REJ;
                idle_from = pg + GAPN + 1;
            end else if (pd == 0) begin
                pk = K_TMO;
                idle_from = pg + ATO + GAPN;
            end else begin
                pk = K_OK;
                cons[w] = cons[w] + pl;
                idle_from = pg + pd + pl + GAPN + 1;
            end
        end
    endtask

    task automatic settle(input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            tick();
            n++;
            if (!act && q0.size() == 0 && q1.size() == 0) break;
        end
        check("settle", 32'(n < budget), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            fifo0[i] = 8'(8'hA0 + i);
            fifo1[i] = 8'($urandom);
        end
        rp[0] = 0; rp[1] = 0;
        cons[0] = 0; cons[1] = 0;
        rst_now = 1; tick();
        rst_now = 1; tick();
        tick(); tick();
        spur = 1;
        q0.push_back('{4, 3});
        settle(200);
        repeat (3) begin
            q0.push_back('{2, 1});
            q1.push_back('{2, 1});
        end
        settle(500);
        q1.push_back('{0, 1});
        q1.push_back('{1473, 1});
        settle(200);
        q0.push_back('{8, 0});
        q1.push_back('{3, 2});
        settle(3000);
        q1.push_back('{5, ATO});
        settle(3000);
        q0.push_back('{MAXL, 2});
        settle(4000);
        en1 = 0;
        q0.push_back('{10, 2});
        q1.push_back('{3, 1});
        for (int k = 0; k < 100 && !(act && psel == 0); k++) tick();
        en1 = 1;
        for (int k = 0; k < 100 && !(act && cyc + 1 - pg == pd + 3); k++) tick();
        rst_now = 1;
        settle(300);
        for (int i = 0; i < 40; i++) begin
            int ch, ln, dl, r;
            r = $urandom_range(0, 19);
            if (r == 0) ln = 0;
            else if (r == 1) ln = $urandom_range(MAXL + 1, 65535);
            else ln = $urandom_range(1, 16);
            dl = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 6);
            ch = $urandom_range(0, 1);
            if (ch != 0) q1.push_back('{ln, dl});
            else q0.push_back('{ln, dl});
            repeat ($urandom_range(0, 25)) tick();
        end
        settle(12000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
